// File: rtl/irq_ctrl.sv
// irq_ctrl: masked, prioritised interrupt controller with CPU ack/EOI handshake
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_irq,
  output logic             cpu_irq,
  output logic [2:0]       irq_id,
  input  logic             cpu_ack,
  output logic [31:0]      dev_out,
  input  logic [31:0]      dev_in,
  input  logic [7:0]       dev_addr,
  input  logic             we
);
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;
  state_t state, state_n;
  logic en, irq_n, ack_fire, eoi;
  logic [2:0] win, id_n;
  logic [7:0] elig8;
  logic [N_SRC-1:0] mask, edge_r, epend, src_q, pend, eligible, rise, chg, clr, ack_clr;
  logic wr_ctrl, wr_mask, wr_edge, wr_pend;
  logic unused;
  assign wr_ctrl = we && dev_addr == 8'h00;
  assign wr_mask = we && dev_addr == 8'h04;
  assign wr_edge = we && dev_addr == 8'h08;
  assign wr_pend = we && dev_addr == 8'h0C;
  assign eoi = we && dev_addr == 8'h10 && state == SERVICE;
  assign ack_fire = cpu_ack && state == ASSERT;
  assign pend = (edge_r & epend) | (~edge_r & src_irq);
  assign eligible = pend & mask & {N_SRC{en}};
  assign elig8 = 8'(eligible);
  assign rise = src_irq & ~src_q;
  assign chg = wr_edge ? (edge_r ^ dev_in[N_SRC-1:0]) : '0;
  assign clr = (wr_pend ? dev_in[N_SRC-1:0] : '0) | ack_clr;
  assign unused = ^dev_in[31:N_SRC];
  // lowest eligible index wins; one-hot clear of the acknowledged source
  always_comb begin
    win = 3'd0;
    ack_clr = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win = 3'(i);
      ack_clr[i] = ack_fire && irq_id == 3'(i);
    end
  end
  // register read mux
  always_comb begin
    dev_out = dev_addr == 8'h00 ? {31'b0, en} :
              dev_addr == 8'h04 ? 32'(mask) :
              dev_addr == 8'h08 ? 32'(edge_r) :
              dev_addr == 8'h0C ? 32'(pend) :
              dev_addr == 8'h10 ? {27'b0, state, irq_id} : 32'b0;
  end
  // handshake FSM next-state; decisions use pre-write register values
  always_comb begin
    state_n = state;
    irq_n = 1'b0;
    id_n = irq_id;
    case (state)
      IDLE: if (|eligible) begin
        state_n = ASSERT;
        id_n = win;
        irq_n = 1'b1;
      end
      ASSERT: if (cpu_ack) state_n = SERVICE;
        else if (!elig8[irq_id]) state_n = IDLE;
        else irq_n = 1'b1;
      SERVICE: if (eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cpu_irq <= 1'b0;
      irq_id <= 3'd0;
    end else begin
      state <= state_n;
      cpu_irq <= irq_n;
      irq_id <= id_n;
    end
  end
  // config registers and edge latches; a new rise beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 1'b0;
      mask <= '0;
      edge_r <= '0;
      epend <= '0;
      src_q <= '0;
    end else begin
      if (wr_ctrl) en <= dev_in[0];
      if (wr_mask) mask <= dev_in[N_SRC-1:0];
      if (wr_edge) edge_r <= dev_in[N_SRC-1:0];
      epend <= ((epend & ~clr) | rise) & edge_r & ~chg;
      src_q <= src_irq;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed vector table plus hand sequences for irq_ctrl
module tb_irq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cpu_irq, cpu_ack = 1'b0, we = 1'b0;
  logic [5:0] src_irq = '0;
  logic [2:0] irq_id;
  logic [31:0] dev_out, dev_in = '0;
  logic [7:0] dev_addr = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [5:0] src; logic ack; logic wen; logic [7:0] addr; logic [31:0] din;
    logic [7:0] raddr; logic irq; logic [2:0] id; logic [31:0] rd;
  } vec_t;
  vec_t vq[$];

  irq_ctrl #(.N_SRC(6)) dut (
    .clk(clk), .rst_n(rst_n), .src_irq(src_irq), .cpu_irq(cpu_irq), .irq_id(irq_id),
    .cpu_ack(cpu_ack), .dev_out(dev_out), .dev_in(dev_in), .dev_addr(dev_addr), .we(we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    dev_addr = a;
    #1;
    chk(name, dev_out, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; dev_addr = a; dev_in = d;
    step();
    we = 1'b0;
  endtask

  task automatic add(input logic [5:0] s, input logic k, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [7:0] ra, input logic q,
                     input logic [2:0] id, input logic [31:0] r);
    vq.push_back('{s, k, w, a, d, ra, q, id, r});
  endtask

  initial begin
    add(6'h00,0,1,8'h00,32'h01,8'h00,0,0,32'h01);
    add(6'h00,0,1,8'h04,32'hFF,8'h04,0,0,32'h3F);
    add(6'h00,0,1,8'h08,32'h00,8'h08,0,0,32'h00);
    add(6'h24,0,0,8'h00,32'h00,8'h0C,1,2,32'h24);
    add(6'h24,1,0,8'h00,32'h00,8'h10,0,2,32'h12);
    add(6'h24,0,0,8'h00,32'h00,8'h10,0,2,32'h12);
    add(6'h24,0,1,8'h10,32'h00,8'h10,0,2,32'h02);
    add(6'h24,0,0,8'h00,32'h00,8'h10,1,2,32'h0A);
    add(6'h24,1,0,8'h00,32'h00,8'h10,0,2,32'h12);
    add(6'h00,0,1,8'h10,32'h00,8'h10,0,2,32'h02);
    add(6'h00,0,0,8'h00,32'h00,8'h10,0,2,32'h02);
    add(6'h00,1,0,8'h00,32'h00,8'h10,0,2,32'h02);
    add(6'h00,0,1,8'h08,32'h01,8'h08,0,2,32'h01);
    add(6'h01,0,0,8'h00,32'h00,8'h0C,0,2,32'h01);
    add(6'h00,0,0,8'h00,32'h00,8'h0C,1,0,32'h01);
    add(6'h00,1,0,8'h00,32'h00,8'h0C,0,0,32'h00);
    add(6'h00,0,1,8'h10,32'h00,8'h10,0,0,32'h00);
    add(6'h08,0,0,8'h00,32'h00,8'h10,1,3,32'h0B);
    add(6'h00,0,0,8'h00,32'h00,8'h10,0,3,32'h03);
    add(6'h08,0,0,8'h00,32'h00,8'h10,1,3,32'h0B);
    add(6'h00,1,0,8'h00,32'h00,8'h10,0,3,32'h13);
    add(6'h00,0,1,8'h10,32'h00,8'h10,0,3,32'h03);
    add(6'h10,0,0,8'h00,32'h00,8'h10,1,4,32'h0C);
    add(6'h14,0,0,8'h00,32'h00,8'h10,1,4,32'h0C);
    add(6'h14,1,0,8'h00,32'h00,8'h10,0,4,32'h14);
    add(6'h14,0,1,8'h10,32'h00,8'h10,0,4,32'h04);
    add(6'h14,0,0,8'h00,32'h00,8'h10,1,2,32'h0A);
    add(6'h00,1,0,8'h00,32'h00,8'h10,0,2,32'h12);
    add(6'h00,0,1,8'h10,32'h00,8'h10,0,2,32'h02);
    add(6'h00,0,1,8'h04,32'h3B,8'h04,0,2,32'h3B);
    add(6'h04,0,0,8'h00,32'h00,8'h10,0,2,32'h02);
    add(6'h04,0,1,8'h04,32'h3F,8'h04,0,2,32'h3F);
    add(6'h04,0,0,8'h00,32'h00,8'h10,1,2,32'h0A);
    add(6'h04,0,1,8'h04,32'h3B,8'h10,1,2,32'h0A);
    add(6'h04,0,0,8'h00,32'h00,8'h10,0,2,32'h02);
    add(6'h00,0,1,8'h04,32'h3F,8'h04,0,2,32'h3F);
    add(6'h00,0,1,8'h00,32'h00,8'h00,0,2,32'h00);
    add(6'h02,0,0,8'h00,32'h00,8'h10,0,2,32'h02);
    add(6'h02,0,1,8'h00,32'h01,8'h00,0,2,32'h01);
    add(6'h02,0,0,8'h00,32'h00,8'h10,1,1,32'h09);
    add(6'h00,1,0,8'h00,32'h00,8'h10,0,1,32'h11);
    add(6'h00,0,1,8'h10,32'h00,8'h10,0,1,32'h01);
    add(6'h00,0,1,8'h14,32'hFFFFFFFF,8'h14,0,1,32'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_irq", 32'(cpu_irq), 32'h0);
    chk("rst_irq_id", 32'(irq_id), 32'h0);
    for (int a = 0; a <= 16; a += 4) rd($sformatf("rst_rd_%0h", a), 8'(a), 32'h0);
    rst_n = 1'b1;
    step();

    foreach (vq[i]) begin
      src_irq = vq[i].src; cpu_ack = vq[i].ack; we = vq[i].wen;
      dev_addr = vq[i].addr; dev_in = vq[i].din;
      step();
      cpu_ack = 1'b0; we = 1'b0; dev_addr = vq[i].raddr;
      #1;
      chk($sformatf("vec%0d_irq", i), 32'(cpu_irq), 32'(vq[i].irq));
      chk($sformatf("vec%0d_id", i), 32'(irq_id), 32'(vq[i].id));
      chk($sformatf("vec%0d_rd", i), dev_out, vq[i].rd);
    end

    src_irq = 6'h00;
    wr(8'h04, 32'h00);
    wr(8'h08, 32'h03);
    src_irq = 6'h02;
    wr(8'h0C, 32'h02);
    rd("race_set_wins", 8'h0C, 32'h02);
    step();
    rd("race_hold", 8'h0C, 32'h02);
    wr(8'h0C, 32'h02);
    rd("w1c_clears", 8'h0C, 32'h00);
    src_irq = 6'h08;
    step();
    rd("level_pend", 8'h0C, 32'h08);
    wr(8'h0C, 32'h08);
    rd("level_ignores_w1c", 8'h0C, 32'h08);
    src_irq = 6'h00;
    step();
    src_irq = 6'h02;
    step();
    rd("edge_relatch", 8'h0C, 32'h02);
    src_irq = 6'h00;
    wr(8'h08, 32'h01);
    rd("edge_to_level", 8'h0C, 32'h00);
    wr(8'h08, 32'h03);
    rd("edge_latch_cleared", 8'h0C, 32'h00);
    chk("idle_no_irq", 32'(cpu_irq), 32'h0);

    wr(8'h04, 32'h3F);
    src_irq = 6'h08;
    step();
    chk("pre_rst_assert", 32'(cpu_irq), 32'h1);
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    src_irq = 6'h00;
    rd("pre_rst_service", 8'h10, 32'h13);
    rst_n = 1'b0;
    dev_addr = 8'h10;
    #1;
    chk("async_rst_id", 32'(irq_id), 32'h0);
    chk("async_rst_irq", 32'(cpu_irq), 32'h0);
    chk("async_rst_stat", dev_out, 32'h0);
    rd("async_rst_ctrl", 8'h00, 32'h0);
    rd("async_rst_mask", 8'h04, 32'h0);
    rd("async_rst_edge", 8'h08, 32'h0);
    rd("async_rst_pend", 8'h0C, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(cpu_irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
